// File: rtl/rv32_regfile_pkg.sv
// rv32_regfile_pkg
// Shared constants and types for the RV32 integer register file.
//   XLEN       : register / data width in bits
//   NUM_REGS   : number of architectural registers (x0..x31)
//   REG_ADDR_W : width of a register index
//   reg_addr_t : register index type used on every address port
package rv32_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // True when the index names the hard-wired zero register.
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port of the register file: zero-register check,
// write-through bypass compare and the storage mux.
// Ports:
//   reset_n    : active-low reset; while low the port returns 0
//   rs_address : register index to read
//   rd_address : index currently being written (bypass compare)
//   rd_value   : data currently being written (bypass data)
//   regs       : storage entries x1..x(NUM_REGS-1), packed
//   rs_value   : read data
module regfile_read_port #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                               reset_n,
  input  logic [ADDR_W-1:0]                  rs_address,
  input  logic [ADDR_W-1:0]                  rd_address,
  input  logic [XLEN-1:0]                    rd_value,
  input  logic [NUM_REGS-1:1][XLEN-1:0]      regs,
  output logic [XLEN-1:0]                    rs_value
);

  logic             is_zero_s;
  logic             bypass_hit_s;
  logic [XLEN-1:0]  array_value_s;

  // Decode the special cases: x0 reads and a same-cycle write to the read index.
  always_comb begin
    is_zero_s    = (rs_address == {ADDR_W{1'b0}});
    bypass_hit_s = 1'b0;
    if (!is_zero_s && (rs_address == rd_address)) begin
      bypass_hit_s = 1'b1;
    end else begin
      bypass_hit_s = 1'b0;
    end
  end

  // Storage mux over entries 1..NUM_REGS-1; x0 has no entry.
  always_comb begin
    array_value_s = {XLEN{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs_address == ADDR_W'(i)) begin
        array_value_s = regs[i];
      end else begin
        array_value_s = array_value_s;
      end
    end
  end

  // Final select: reset and x0 force zero, then bypass wins over stored data.
  always_comb begin
    rs_value = {XLEN{1'b0}};
    if (!reset_n) begin
      rs_value = {XLEN{1'b0}};
    end else if (is_zero_s) begin
      rs_value = {XLEN{1'b0}};
    end else if (bypass_hit_s) begin
      rs_value = rd_value;
    end else begin
      rs_value = array_value_s;
    end
  end

endmodule

// File: rtl/rv32_regfile.sv
// rv32_regfile
// RV32 integer register file: two combinational read ports with write-through
// bypass, one write port that writes on every clock edge (no enable), x0
// hard-wired to zero.
// Ports:
//   clk         : clock, state updates on rising edge
//   reset_n     : asynchronous active-low reset, clears x1..x31 immediately
//   rs1_address : read port 1 index
//   rs2_address : read port 2 index
//   rd_address  : write index (x0 writes are discarded)
//   rd_value    : write data
//   rs1_value_o : read port 1 data
//   rs2_value_o : read port 2 data
module rv32_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  rv32_regfile_pkg::reg_addr_t rs1_address,
  input  rv32_regfile_pkg::reg_addr_t rs2_address,
  input  rv32_regfile_pkg::reg_addr_t rd_address,
  input  logic [XLEN-1:0]            rd_value,
  output logic [XLEN-1:0]            rs1_value_o,
  output logic [XLEN-1:0]            rs2_value_o
);

  import rv32_regfile_pkg::*;

  // Entries 1..NUM_REGS-1 only; x0 is a constant zero provided by the read ports.
  logic [NUM_REGS-1:1][XLEN-1:0] regs_r;
  logic                          write_x0_s;

  // Writes aimed at x0 are dropped before reaching the storage.
  always_comb begin
    write_x0_s = is_x0(rd_address);
  end

  // Storage update: async clear, otherwise load rd_value into the addressed entry every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_r <= '0;
    end else if (!write_x0_s) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_address == REG_ADDR_W'(i)) begin
          regs_r[i] <= rd_value;
        end
      end
    end
  end

  regfile_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_read_port1 (
    .reset_n    (reset_n),
    .rs_address (rs1_address),
    .rd_address (rd_address),
    .rd_value   (rd_value),
    .regs       (regs_r),
    .rs_value   (rs1_value_o)
  );

  regfile_read_port #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (REG_ADDR_W)
  ) u_read_port2 (
    .reset_n    (reset_n),
    .rs_address (rs2_address),
    .rd_address (rd_address),
    .rd_value   (rd_value),
    .regs       (regs_r),
    .rs_value   (rs2_value_o)
  );

endmodule

// File: tb/tb_rv32_regfile.sv
// tb_rv32_regfile
// Directed and randomized checks of rv32_regfile against a simple array model:
// a write lands in the model on each rising edge while reset_n is high, and a
// read returns 0 for x0 or during reset, the in-flight write data on an
// address match, or the stored model value otherwise.
module tb_rv32_regfile;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic [4:0]  rd_address;
  logic [31:0] rd_value;
  logic [31:0] rs1_value_o;
  logic [31:0] rs2_value_o;

  logic [31:0] model [0:31];
  int          n_checks;
  int          n_fail;

  rv32_regfile dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .rd_address  (rd_address),
    .rd_value    (rd_value),
    .rs1_value_o (rs1_value_o),
    .rs2_value_o (rs2_value_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expect_read(input logic [4:0] a);
    if (!reset_n) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (a == rd_address) return rd_value;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: apply the edge's write to the model, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset_n && rd_address != 5'd0) model[rd_address] = rd_value;
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    clear_model();
    reset_n     = 1'b0;
    rd_address  = 5'd3;
    rd_value    = 32'hDEAD_BEEF;
    rs1_address = 5'd0;
    rs2_address = 5'd0;

    // Reset: every address on both ports reads 0, bypass suppressed.
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1_address = 5'(a);
      rs2_address = 5'(31 - a);
      #1;
      check("reset_rs1", rs1_value_o, 32'd0);
      check("reset_rs2", rs2_value_o, 32'd0);
    end
    // Writes blocked while in reset, even across edges.
    repeat (2) cycle();
    rs1_address = 5'd3;
    #1;
    check("reset_no_write", rs1_value_o, 32'd0);

    // Release at a falling edge with a harmless x0 write.
    @(negedge clk);
    rd_address = 5'd0;
    reset_n    = 1'b1;
    cycle();

    // Bypass then stored value for x4.
    rd_address  = 5'd4;
    rd_value    = 32'd546;
    rs1_address = 5'd4;
    rs2_address = 5'd4;
    #1;
    check("bypass_rs1", rs1_value_o, 32'd546);
    check("bypass_rs2", rs2_value_o, 32'd546);
    cycle();
    rd_address = 5'd7;
    rd_value   = 32'd999;
    #1;
    check("stored_x4_rs1", rs1_value_o, 32'd546);
    check("stored_x4_rs2", rs2_value_o, 32'd546);
    cycle();

    // Writes to x0 are discarded; x4 untouched.
    rd_address  = 5'd0;
    rd_value    = 32'd654;
    rs1_address = 5'd0;
    rs2_address = 5'd0;
    #1;
    check("x0_bypass_rs1", rs1_value_o, 32'd0);
    check("x0_bypass_rs2", rs2_value_o, 32'd0);
    cycle();
    #1;
    check("x0_after_rs1", rs1_value_o, 32'd0);
    rs1_address = 5'd4;
    #1;
    check("x4_kept", rs1_value_o, 32'd546);

    // Fill x1..x31 with (i+1)*12 on consecutive edges.
    for (int i = 1; i < 32; i++) begin
      rd_address = 5'(i);
      rd_value   = 32'((i + 1) * 12);
      cycle();
    end
    rd_address = 5'd0;
    rd_value   = 32'hFFFF_FFFF;
    for (int a = 0; a < 32; a++) begin
      rs1_address = 5'(a);
      rs2_address = 5'(31 - a);
      #1;
      check("fill_rs1", rs1_value_o, (a == 0) ? 32'd0 : 32'((a + 1) * 12));
      check("fill_rs2", rs2_value_o, (a == 31) ? 32'd0 : 32'((32 - a) * 12));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      rd_address  = 5'($urandom_range(0, 31));
      rd_value    = $urandom;
      rs1_address = 5'($urandom_range(0, 31));
      rs2_address = ($urandom_range(0, 3) == 0) ? rd_address : 5'($urandom_range(0, 31));
      #1;
      check("rand_rs1", rs1_value_o, expect_read(rs1_address));
      check("rand_rs2", rs2_value_o, expect_read(rs2_address));
      cycle();
    end

    // Refill so x5 is known non-zero before the reset test.
    rd_address = 5'd5;
    rd_value   = 32'd72;
    cycle();
    rd_address  = 5'd5;
    rd_value    = 32'h1234_5678;
    rs1_address = 5'd5;
    #1;
    check("pre_reset_x5", rs1_value_o, 32'h1234_5678);

    // Mid-cycle asynchronous reset: everything reads 0 without a clock edge.
    #1;
    reset_n = 1'b0;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      rs1_address = 5'(a);
      rs2_address = 5'(a);
      #1;
      check("async_rst_rs1", rs1_value_o, 32'd0);
      check("async_rst_rs2", rs2_value_o, 32'd0);
    end

    // Release with a write presented on the first edge; it must complete.
    @(negedge clk);
    reset_n     = 1'b1;
    rd_address  = 5'd9;
    rd_value    = 32'h0000_ABCD;
    rs1_address = 5'd5;
    rs2_address = 5'd5;
    #1;
    check("post_rst_x5", rs1_value_o, 32'd0);
    cycle();
    rd_address  = 5'd0;
    rs1_address = 5'd9;
    #1;
    check("release_edge_write", rs1_value_o, 32'h0000_ABCD);
    check("x5_still_zero", rs2_value_o, 32'd0);
    rd_address = 5'd5;
    rd_value   = 32'd77;
    cycle();
    rd_address = 5'd0;
    #1;
    check("x5_rewritten", rs2_value_o, 32'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
